// File: rtl/lstm_mem_pkg.sv
// Shared definitions for the 512x32 weight/state SRAM and the blocks that
// access it: geometry constants, the burst reader state encoding and the
// wrap-around address helper.
package lstm_mem_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  // Word address of offset 'off' within a burst starting at 'base'.
  // Truncation to ADDR_W bits gives the 511 -> 0 wrap for free.
  function automatic logic [ADDR_W-1:0] wrap_addr(
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W:0]   off
  );
    return base + off[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sram_burst_reader.sv
// sram_burst_reader
//   Streams LEN consecutive words out of the 512x32 SRAM, starting at
//   BASE_ADDR, onto a valid/ready interface at one word per cycle.
//   The SRAM registers ADDR when EN_M is high and drives DOUT
//   combinationally from that captured address, so OUT_DATA is a direct
//   pass-through of SRAM_DOUT. Backpressure is handled by withholding EN_M:
//   the captured address, and therefore OUT_DATA, holds until the beat is
//   accepted. No data buffer is needed.
//
// Ports
//   CLK, RST      clock (rising edge), synchronous active-high reset
//   START         burst request, only looked at while idle
//   BASE_ADDR     first word address, latched when START is accepted
//   LEN           word count 0..512, latched when START is accepted
//   BUSY          high whenever a burst is in progress
//   DONE          one-cycle pulse when a burst (including LEN=0) finishes
//   SRAM_EN_M     SRAM address-capture enable
//   SRAM_ADDR     SRAM address
//   SRAM_DOUT     SRAM read data
//   OUT_VALID     OUT_DATA holds a beat
//   OUT_READY     downstream takes the beat this cycle
//   OUT_DATA      beat data (= SRAM_DOUT)
//   OUT_LAST      marks the final beat of the burst
module sram_burst_reader
  import lstm_mem_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              SRAM_EN_M,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic [DATA_W-1:0] SRAM_DOUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_LAST
);

  localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   issued_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic              done_r;

  logic              iss_s;          // SRAM fetch this cycle
  logic              start_burst_s;  // non-empty burst accepted
  logic              empty_burst_s;  // LEN=0 request: complete at once
  logic              finish_s;       // final beat handed off

  // Next-state, fetch-issue and completion decode.
  always_comb begin
    state_nxt_s   = state_r;
    iss_s         = 1'b0;
    start_burst_s = 1'b0;
    empty_burst_s = 1'b0;
    finish_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (START) begin
          if (LEN != CNT_ZERO) begin
            start_burst_s = 1'b1;
            state_nxt_s   = FETCH;
          end else begin
            empty_burst_s = 1'b1;
            state_nxt_s   = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        // A new fetch is allowed only when the output slot is empty or is
        // being drained this cycle; otherwise the SRAM must keep its address.
        iss_s    = (issued_r < len_r) && (!out_valid_r || OUT_READY);
        finish_s = out_valid_r && OUT_READY && out_last_r;
        if (finish_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst parameters, issue counter and output-stage flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      base_r      <= {ADDR_W{1'b0}};
      len_r       <= CNT_ZERO;
      issued_r    <= CNT_ZERO;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= empty_burst_s || finish_s;

      if (start_burst_s) begin
        base_r   <= BASE_ADDR;
        len_r    <= LEN;
        issued_r <= CNT_ZERO;
      end else if (iss_s) begin
        issued_r <= issued_r + CNT_ONE;
      end else begin
        issued_r <= issued_r;
      end

      // The word fetched on this edge becomes visible right after it, so
      // valid/last are set together with the issue that produced the beat.
      if (iss_s) begin
        out_valid_r <= 1'b1;
        out_last_r  <= (issued_r == (len_r - CNT_ONE));
      end else if (OUT_READY) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
        out_last_r  <= out_last_r;
      end
    end
  end

  assign BUSY      = (state_r != IDLE);
  assign DONE      = done_r;
  assign SRAM_EN_M = iss_s;
  assign SRAM_ADDR = wrap_addr(base_r, issued_r);
  assign OUT_VALID = out_valid_r;
  assign OUT_LAST  = out_last_r;
  assign OUT_DATA  = SRAM_DOUT;

endmodule

// File: doc/sram_burst_reader.md
Name: sram_burst_reader

Overview:
- Sequences burst reads out of the 512x32 weight/state SRAM and presents the words downstream on a valid/ready stream, one word per cycle at full throughput.
- Drives the SRAM's EN_M and ADDR and consumes its DOUT. The SRAM registers ADDR on EN_M and returns DOUT combinationally from the captured address.
- Backpressure is absorbed by deasserting EN_M, which holds the SRAM's captured address. No local data buffer is needed.

Parameters:
- ADDR_W, 9, SRAM address width.
- DATA_W, 32, SRAM word width.
- DEPTH, 512, number of SRAM words (2**ADDR_W).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  burst request; sampled only in IDLE.
- BASE_ADDR  in  ADDR_W  first word address; latched on accepted START.
- LEN  in  ADDR_W+1  word count, 0..DEPTH; latched on accepted START.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse on completion of a burst.
- SRAM_EN_M  out  1  to SRAM EN_M.
- SRAM_ADDR  out  ADDR_W  to SRAM ADDR.
- SRAM_DOUT  in  DATA_W  from SRAM DOUT.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  downstream accepts the beat.
- OUT_DATA  out  DATA_W  equal to SRAM_DOUT, combinational pass-through.
- OUT_LAST  out  1  qualifies the final beat of a burst.

Behaviour:
- Reset: RST is synchronous and active-high; CLK is the single clock. On the edge where RST=1:
  - state<=IDLE; issue and beat counters <=0; OUT_VALID<=0; OUT_LAST<=0; DONE<=0.
  - SRAM_EN_M is 0 while in IDLE.
  - Reset mid-burst abandons the burst with no DONE pulse.
- States: IDLE, FETCH.
- IDLE -> FETCH: START=1 and LEN!=0. Latch BASE_ADDR and LEN; issued<=0.
- IDLE, START=1 and LEN==0: stay in IDLE, DONE<=1 for one cycle, no SRAM access.
- Issue condition (combinational): iss = (state==FETCH) && (issued<len) && (!OUT_VALID || OUT_READY).
- SRAM_EN_M = iss. SRAM_ADDR = (base + issued) mod DEPTH; the address wraps 511 -> 0.
- On an edge with iss=1:
  - issued <= issued+1.
  - OUT_VALID <= 1.
  - OUT_LAST <= (issued == len-1).
- On an edge with iss=0 and OUT_READY=1: OUT_VALID<=0 and OUT_LAST<=0.
- Stall: while OUT_VALID && !OUT_READY, EN_M=0. The SRAM's captured address holds, so OUT_DATA stays stable. This satisfies the rule that valid must not drop and data must not change before the handshake.
- Latency: START is sampled at edge t0. EN_M=1 with ADDR=base during cycle t0..t1. OUT_VALID=1 with OUT_DATA=mem[base] after edge t1.
- Throughput: 1 beat/cycle with OUT_READY held high.
- Completion: the handshake (OUT_VALID && OUT_READY && OUT_LAST) moves FETCH -> IDLE and pulses DONE for one cycle. OUT_VALID falls on the same edge.
- START while BUSY is ignored.
- A new START is accepted in the cycle after DONE.
- Caller contract:
  - No SRAM writes may target the burst range while BUSY.
  - START must come at least 2 cycles after the last WE to that range, because the SRAM write path is 2-stage.
- Widths: issued and len are ADDR_W+1 bits. The address sum is truncated to ADDR_W bits.

Decomposition:
- Package lstm_mem_pkg holds ADDR_W, DATA_W, DEPTH and the state enum {IDLE, FETCH}. The SRAM wrapper reuses these.
- No sub-module; a single flat module.
- The bench instantiates the real SRAM behind the reader.

Test Plan:
- Preload mem[k]=32'hA000_0000+k. BASE=5, LEN=4, OUT_READY=1 -> OUT_DATA A0000005..A0000008 on 4 consecutive cycles starting 2 edges after START. OUT_LAST on the 4th beat; DONE on the edge after the 4th beat.
- BASE=510, LEN=4 -> beats from addresses 510, 511, 0, 1 (wrap-around), then DONE.
- BASE=0, LEN=6, OUT_READY toggling 1,0,0,1,... -> EN_M=0 whenever a beat is pending unaccepted. OUT_DATA stable across stalls. All 6 words are delivered in order with no duplicates or drops.
- LEN=0 -> DONE pulse 1 cycle after START, EN_M never asserted, OUT_VALID stays 0. LEN=512 -> all 512 words delivered, OUT_LAST only on the final beat.
- RST=1 asserted after 3 beats of an 8-beat burst -> next cycle BUSY=0, OUT_VALID=0, EN_M=0, no DONE. A following burst BASE=20, LEN=2 returns mem[20], mem[21].
- START pulsed again mid-burst with different BASE -> ignored, and the original burst completes unchanged.
